// File: rtl/calendar_pkg.sv
// Shared types and field limits for the time-of-day run/set controller.
package calendar_pkg;

    localparam int unsigned TIME_W    = 6;
    localparam int unsigned HOURS_MAX = 23;
    localparam int unsigned MINS_MAX  = 59;
    localparam int unsigned SECS_MAX  = 59;

    // Encoding doubles as the FIELD output value.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        EDIT_S = 2'd3
    } field_e;

endpackage

// File: rtl/calendar_ctrl_if.sv
// Button, live-time and load/tick signals between front panel, counter and controller.
interface calendar_ctrl_if #(
    parameter int unsigned TIME_W = calendar_pkg::TIME_W
);
    logic              MODE;
    logic              INC;
    logic              DEC;
    logic [TIME_W-1:0] CUR_HOURS;
    logic [TIME_W-1:0] CUR_MINS;
    logic [TIME_W-1:0] CUR_SECS;
    logic              TICK;
    logic              LOAD;
    logic [TIME_W-1:0] LOAD_HOURS;
    logic [TIME_W-1:0] LOAD_MINS;
    logic [TIME_W-1:0] LOAD_SECS;
    logic [1:0]        FIELD;

    modport master (
        output MODE, INC, DEC, CUR_HOURS, CUR_MINS, CUR_SECS,
        input  TICK, LOAD, LOAD_HOURS, LOAD_MINS, LOAD_SECS, FIELD
    );

    modport slave (
        input  MODE, INC, DEC, CUR_HOURS, CUR_MINS, CUR_SECS,
        output TICK, LOAD, LOAD_HOURS, LOAD_MINS, LOAD_SECS, FIELD
    );
endinterface

// File: rtl/calendar_tick_gen.sv
// Prescaler producing a registered one-cycle TICK every CLK_DIV enabled cycles.
module calendar_tick_gen #(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic enable,
    input  logic clear,
    output logic TICK
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // clear only restarts the count; a tick due on the same edge still fires.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
            TICK  <= 1'b0;
        end else begin
            TICK <= enable && (count == LAST);
            if (clear || !enable || (count == LAST))
                count <= '0;
            else
                count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/calendar_ctrl.sv
// Run/set controller: 1 Hz tick generation plus the MODE/INC/DEC time-setting FSM.
module calendar_ctrl #(
    parameter int unsigned CLK_DIV = 50000000,
    parameter int unsigned TIME_W  = 6
) (
    input  logic            CLK,
    input  logic            RST_N,
    calendar_ctrl_if.slave  bus
);
    import calendar_pkg::*;

    localparam logic [TIME_W-1:0] H_MAX = TIME_W'(HOURS_MAX);
    localparam logic [TIME_W-1:0] M_MAX = TIME_W'(MINS_MAX);
    localparam logic [TIME_W-1:0] S_MAX = TIME_W'(SECS_MAX);

    field_e            state;
    logic              load;
    logic              tick;
    logic [TIME_W-1:0] hours;
    logic [TIME_W-1:0] mins;
    logic [TIME_W-1:0] secs;

    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return (v >= max) ? '0 : v + TIME_W'(1);
    endfunction

    function automatic logic [TIME_W-1:0] wrap_dec(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
        return ((v == '0) || (v > max)) ? max : v - TIME_W'(1);
    endfunction

    calendar_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .enable (state == RUN),
        .clear  (bus.MODE),
        .TICK   (tick)
    );

    // MODE has priority; INC together with DEC cancels out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RUN;
            load  <= 1'b0;
            hours <= '0;
            mins  <= '0;
            secs  <= '0;
        end else begin
            load <= 1'b0;
            if (bus.MODE) begin
                unique case (state)
                    RUN: begin
                        state <= EDIT_H;
                        hours <= bus.CUR_HOURS;
                        mins  <= bus.CUR_MINS;
                        secs  <= bus.CUR_SECS;
                    end
                    EDIT_H: state <= EDIT_M;
                    EDIT_M: state <= EDIT_S;
                    EDIT_S: begin
                        state <= RUN;
                        load  <= 1'b1;
                    end
                endcase
            end else if (bus.INC ^ bus.DEC) begin
                unique case (state)
                    RUN:    ;
                    EDIT_H: hours <= bus.INC ? wrap_inc(hours, H_MAX) : wrap_dec(hours, H_MAX);
                    EDIT_M: mins  <= bus.INC ? wrap_inc(mins, M_MAX)  : wrap_dec(mins, M_MAX);
                    EDIT_S: secs  <= bus.INC ? wrap_inc(secs, S_MAX)  : wrap_dec(secs, S_MAX);
                endcase
            end
        end
    end

    assign bus.TICK       = tick;
    assign bus.LOAD       = load;
    assign bus.LOAD_HOURS = hours;
    assign bus.LOAD_MINS  = mins;
    assign bus.LOAD_SECS  = secs;
    assign bus.FIELD      = state;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Scoreboard bench for calendar_ctrl with CLK_DIV = 4.
module tb_calendar_ctrl;

    typedef struct {
        int f;
        int h;
        int m;
        int s;
    } snap_t;

    logic CLK = 1'b0;
    logic RST_N;
    bit   done = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    snap_t snap_q[$];
    snap_t load_q[$];
    int    tick_q[$];

    calendar_ctrl_if #(.TIME_W(6)) bus ();

    calendar_ctrl #(
        .CLK_DIV (4),
        .TIME_W  (6)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic pulse(input logic m, input logic i, input logic d);
        bus.MODE = m;
        bus.INC  = i;
        bus.DEC  = d;
        @(posedge CLK);
        #1;
        bus.MODE = 1'b0;
        bus.INC  = 1'b0;
        bus.DEC  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus.CUR_HOURS = 6'(h);
        bus.CUR_MINS  = 6'(m);
        bus.CUR_SECS  = 6'(s);
    endtask

    task automatic exp_snap(input int f, input int h, input int m, input int s);
        snap_q.push_back('{f, h, m, s});
    endtask

    task automatic exp_load(input int h, input int m, input int s);
        load_q.push_back('{0, h, m, s});
    endtask

    // Stimulus
    initial begin
        RST_N = 1'b1;
        bus.MODE = 1'b0;
        bus.INC  = 1'b0;
        bus.DEC  = 1'b0;
        set_cur(0, 0, 0);
        #1 RST_N = 1'b0;
        exp_snap(0, 0, 0, 0);
        tick_q.push_back(4);
        tick_q.push_back(8);
        tick_q.push_back(12);
        #11 RST_N = 1'b1;

        // Free run with INC/DEC ignored in RUN
        idle(6);
        pulse(0, 1, 0);
        exp_snap(0, 0, 0, 0);
        pulse(0, 0, 1);
        idle(4);

        // Main edit sequence: 10:20:30 -> 13:59:30
        set_cur(10, 20, 30);
        pulse(1, 0, 0);
        exp_snap(1, 10, 20, 30);
        repeat (3) pulse(0, 1, 0);
        exp_snap(1, 13, 20, 30);
        pulse(1, 0, 0);
        repeat (21) pulse(0, 0, 1);
        exp_snap(2, 13, 59, 30);
        pulse(1, 0, 0);
        exp_snap(3, 13, 59, 30);
        exp_load(13, 59, 30);
        pulse(1, 0, 0);
        tick_q.push_back(cyc + 4);
        exp_snap(0, 13, 59, 30);
        idle(4);

        // Wrap-around and simultaneous-button cases
        set_cur(23, 0, 0);
        pulse(1, 0, 0);
        exp_snap(1, 23, 0, 0);
        pulse(0, 1, 0);
        exp_snap(1, 0, 0, 0);
        pulse(0, 0, 1);
        exp_snap(1, 23, 0, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        exp_snap(2, 23, 1, 0);
        pulse(0, 1, 1);
        exp_snap(2, 23, 1, 0);
        pulse(1, 1, 0);
        exp_snap(3, 23, 1, 0);
        pulse(0, 0, 1);
        exp_snap(3, 23, 1, 59);
        pulse(0, 1, 0);
        exp_snap(3, 23, 1, 0);
        exp_load(23, 1, 0);
        pulse(1, 0, 0);
        tick_q.push_back(cyc + 4);
        idle(4);

        // Reset while editing minutes
        set_cur(5, 6, 7);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        exp_snap(2, 5, 7, 7);
        @(negedge CLK);
        #1;
        exp_snap(0, 0, 0, 0);
        RST_N = 1'b0;
        @(negedge CLK);
        tick_q.push_back(4);
        #2 RST_N = 1'b1;
        idle(4);

        // MODE on the edge where the prescaler wraps
        idle(3);
        set_cur(1, 2, 3);
        tick_q.push_back(8);
        pulse(1, 0, 0);
        bus.CUR_SECS = 6'd4;
        exp_snap(1, 1, 2, 3);
        idle(8);
        exp_snap(1, 1, 2, 3);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        exp_load(1, 2, 3);
        pulse(1, 0, 0);
        tick_q.push_back(cyc + 4);
        idle(5);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        snap_t e;
        int    t;
        forever begin
            @(negedge CLK);
            if (done) break;
            if (bus.TICK) begin
                n_chk++;
                if (tick_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tick: unexpected TICK at edge %0d", cyc);
                end else begin
                    t = tick_q.pop_front();
                    if (t != cyc) begin
                        n_fail++;
                        $display("FAIL tick: TICK at edge %0d, expected edge %0d", cyc, t);
                    end
                end
            end
            if (bus.LOAD) begin
                n_chk++;
                if (load_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL load: unexpected LOAD at edge %0d", cyc);
                end else begin
                    e = load_q.pop_front();
                    if (int'(bus.LOAD_HOURS) != e.h || int'(bus.LOAD_MINS) != e.m ||
                        int'(bus.LOAD_SECS) != e.s || bus.FIELD != 2'd0) begin
                        n_fail++;
                        $display("FAIL load: got %0d:%0d:%0d field %0d, expected %0d:%0d:%0d field 0",
                                 bus.LOAD_HOURS, bus.LOAD_MINS, bus.LOAD_SECS, bus.FIELD,
                                 e.h, e.m, e.s);
                    end
                end
            end
            if (snap_q.size() != 0) begin
                e = snap_q.pop_front();
                n_chk++;
                if (int'(bus.FIELD) != e.f || int'(bus.LOAD_HOURS) != e.h ||
                    int'(bus.LOAD_MINS) != e.m || int'(bus.LOAD_SECS) != e.s) begin
                    n_fail++;
                    $display("FAIL snap@%0d: got field %0d %0d:%0d:%0d, expected field %0d %0d:%0d:%0d",
                             cyc, bus.FIELD, bus.LOAD_HOURS, bus.LOAD_MINS, bus.LOAD_SECS,
                             e.f, e.h, e.m, e.s);
                end
            end
        end
        n_chk++;
        if (tick_q.size() != 0) begin
            n_fail++;
            $display("FAIL tick_drain: %0d expected TICKs never seen, expected 0", tick_q.size());
        end
        n_chk++;
        if (load_q.size() != 0 || snap_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d loads %0d snaps pending, expected 0 0",
                     load_q.size(), snap_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: test did not complete by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/calendar_ctrl.md
Name: calendar_ctrl

Overview:
Run/set controller for the hours-minutes-seconds time-of-day counter. It generates the 1 Hz advance enable (TICK) from the system clock, and runs a button-driven set-mode state machine that edits hours, then minutes, then seconds. On exit from set mode it issues a one-cycle LOAD of the edited time into the counter. It sits between the debounced front-panel button logic and the time counter.

Parameters:
CLK_DIV, 50000000, CLK cycles per TICK; legal range >= 2.
TIME_W, 6, width of the hours/minutes/seconds fields.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous, active-low reset.
MODE  input  1  single-cycle pulse, synchronous to CLK; advances the set-mode FSM.
INC  input  1  single-cycle pulse; increments the selected field.
DEC  input  1  single-cycle pulse; decrements the selected field.
CUR_HOURS  input  TIME_W  live hours from the counter (0..23).
CUR_MINS  input  TIME_W  live minutes (0..59).
CUR_SECS  input  TIME_W  live seconds (0..59).
TICK  output  1  one-cycle advance enable to the counter.
LOAD  output  1  one-cycle load strobe to the counter.
LOAD_HOURS  output  TIME_W  edited hours value.
LOAD_MINS  output  TIME_W  edited minutes value.
LOAD_SECS  output  TIME_W  edited seconds value.
FIELD  output  2  current state: 0 = RUN, 1 = EDIT_H, 2 = EDIT_M, 3 = EDIT_S.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = RUN, prescaler = 0, TICK = 0, LOAD = 0.
  - LOAD_HOURS, LOAD_MINS and LOAD_SECS = 0; FIELD = 0.
- Prescaler: counter width $clog2(CLK_DIV); it counts only in RUN.
  - On an edge with count == CLK_DIV-1: count <= 0 and TICK <= 1. On all other edges TICK <= 0.
  - Result: TICK is registered, one cycle wide, and high after edges CLK_DIV, 2*CLK_DIV, ... following reset release.
- FSM transitions, all on a MODE pulse:
  - RUN -> EDIT_H: edit registers capture CUR_HOURS, CUR_MINS and CUR_SECS on that edge.
  - EDIT_H -> EDIT_M, then EDIT_M -> EDIT_S.
  - EDIT_S -> RUN: LOAD <= 1 for exactly one cycle, and prescaler <= 0.
- After a LOAD: the first TICK comes CLK_DIV edges after the exit edge, so the loaded second lasts a full period.
- Edit states:
  - Prescaler is held at 0 and TICK stays 0.
  - LOAD_* continuously reflect the edit registers and are valid at least during the LOAD cycle.
- INC/DEC act on the selected field only and take effect on the same edge. Wrap-around:
  - hours: 23 + INC -> 0 and 0 + DEC -> 23.
  - minutes/seconds: 59 + INC -> 0 and 0 + DEC -> 59.
  - Arithmetic is done at TIME_W bits with an explicit compare-to-max; there is never an out-of-range value.
- Simultaneous events:
  - INC and DEC together: no change.
  - MODE together with INC or DEC: MODE wins and INC/DEC are ignored that cycle.
  - INC/DEC in RUN: ignored.
- A tick due on the same edge as MODE in RUN: TICK still asserts on that edge, and the capture takes the pre-tick CUR_* values. Capturing them is correct because the counter updates on the same edge.
- Reset mid-edit: return to RUN, no LOAD issued, edits discarded.
- Outputs are registered and there is no combinational path from input to output.

Decomposition:
- Package calendar_pkg holds:
  - the state enum {RUN, EDIT_H, EDIT_M, EDIT_S} with 2-bit encoding equal to FIELD;
  - TIME_W = 6, HOURS_MAX = 23, MINS_MAX = 59, SECS_MAX = 59.
- Sub-module calendar_tick_gen: the prescaler, with inputs CLK, RST_N, enable and clear, output TICK, and parameter CLK_DIV.
- The FSM and edit registers stay in calendar_ctrl.

Test Plan:
- CLK_DIV = 4, release reset, no buttons -> TICK high after edges 4, 8, 12; LOAD stays 0; FIELD = 0.
- CUR = 10:20:30, then MODE -> FIELD = 1, TICK stops. Apply INC x3, MODE, DEC x21, MODE, MODE -> one LOAD cycle with LOAD_* = 13:59:30, FIELD = 0, next TICK 4 edges later.
- Wrap-around:
  - EDIT_H at 23 + INC -> 0; then DEC -> 23.
  - EDIT_S at 0 + DEC -> 59; then INC -> 0.
- INC and DEC in the same cycle in EDIT_M -> value unchanged. MODE + INC in the same cycle -> state advances, value unchanged.
- Assert RST_N low while in EDIT_M, mid-cycle -> outputs clear immediately; after release FIELD = 0, no LOAD, TICK resumes at edge 4.
- MODE arrives on the edge where the prescaler hits CLK_DIV-1 -> TICK pulses once, edit capture equals the pre-tick CUR_*, and no further TICK until exit.
